// File: rtl/pwm_pkg.sv
// Shared types and constants for the 3-phase PWM configuration sequencer and the PWM core.
package pwm_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMING   = 2'd1,
        RUNNING  = 2'd2,
        FAULT    = 2'd3
    } state_e;

    localparam logic [2:0] ADDR_LIM  = 3'd0;
    localparam logic [2:0] ADDR_MAT0 = 3'd1;
    localparam logic [2:0] ADDR_DT0  = 3'd4;
    localparam logic [2:0] ADDR_CTRL = 3'd7;

    localparam int NUM_PH = 3;

    // Power-on values also used by the PWM core so both sides agree out of reset
    localparam int unsigned LIM_RST_DEF = 3;
    localparam int unsigned MAT_RST_DEF = 2;
    localparam int unsigned DT_RST_DEF  = 'h3FF;

endpackage

// File: rtl/pwm_wdog.sv
// Saturating period watchdog: counts enabled cycles since the last clear, flags the cycle it reaches CYCLES.
module pwm_wdog #(
    parameter int unsigned CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the increment that reaches CYCLES, so the state change lands exactly CYCLES edges after the clear
    assign timeout_o = en_i && !clr_i && (cnt_q >= CNT_MAX - 1'b1);

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Staging/commit of PWM limit, match and deadtime values plus output-enable sequencing and fault latching.
module pwm_cfg_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned    CNT_W       = 32,
    parameter int unsigned    DT_W        = 10,
    parameter int unsigned    WDOG_CYCLES = 4096,
    parameter logic [CNT_W-1:0] LIM_RST   = CNT_W'(LIM_RST_DEF),
    parameter logic [CNT_W-1:0] MAT_RST   = CNT_W'(MAT_RST_DEF),
    parameter logic [DT_W-1:0]  DT_RST    = DT_W'(DT_RST_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [2:0]              wr_addr,
    input  logic [CNT_W-1:0]        wr_data,
    input  logic                    commit_req,
    input  logic                    period_start,
    input  logic                    fault_in,
    input  logic                    fault_clr,
    output logic [CNT_W-1:0]        lim_out,
    output logic [NUM_PH*CNT_W-1:0] mat_out,
    output logic [NUM_PH*DT_W-1:0]  dt_out,
    output logic                    dten_out,
    output logic                    out_en,
    output logic                    commit_pending,
    output logic                    commit_done,
    output logic                    cfg_err,
    output logic                    wr_err,
    output logic [1:0]              state
);

    logic [CNT_W-1:0]  lim_stg_q, lim_act_q;
    logic [NUM_PH-1:0] mat_ok;
    logic              run_req_q, dten_req_q, dten_hold_q;
    logic              pending_q, done_q, cfg_err_q, wr_err_q;
    logic              arm_seen_q, arm_seen_d;
    logic              fault_exit;
    logic              wdog_to;
    state_e            state_q, state_d;

    logic cfg_wr, stg_wr_ok, ctrl_wr, commit_take, stg_valid, xfer;

    assign cfg_wr      = wr_en && (wr_addr != ADDR_CTRL);
    assign stg_wr_ok   = cfg_wr && !pending_q;
    assign ctrl_wr     = wr_en && (wr_addr == ADDR_CTRL);
    assign commit_take = commit_req && !pending_q && (state_q != FAULT);
    assign stg_valid   = (lim_stg_q != '0) && (&mat_ok);
    assign xfer        = pending_q && period_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            lim_stg_q <= LIM_RST;
            lim_act_q <= LIM_RST;
        end else begin
            if (stg_wr_ok && wr_addr == ADDR_LIM) lim_stg_q <= wr_data;
            if (xfer) lim_act_q <= lim_stg_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PH; gi++) begin : g_ph
            localparam logic [2:0] A_MAT = ADDR_MAT0 + 3'(gi);
            localparam logic [2:0] A_DT  = ADDR_DT0 + 3'(gi);
            logic [CNT_W-1:0] mat_stg_q, mat_act_q;
            logic [DT_W-1:0]  dt_stg_q, dt_act_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    mat_stg_q <= MAT_RST;
                    mat_act_q <= MAT_RST;
                    dt_stg_q  <= DT_RST;
                    dt_act_q  <= DT_RST;
                end else begin
                    if (stg_wr_ok && wr_addr == A_MAT) mat_stg_q <= wr_data;
                    if (stg_wr_ok && wr_addr == A_DT)  dt_stg_q  <= wr_data[DT_W-1:0];
                    if (xfer) begin
                        mat_act_q <= mat_stg_q;
                        dt_act_q  <= dt_stg_q;
                    end
                end
            end

            assign mat_ok[gi]                    = (mat_stg_q <= lim_stg_q);
            assign mat_out[gi*CNT_W +: CNT_W]    = mat_act_q;
            assign dt_out[gi*DT_W +: DT_W]       = dt_act_q;
        end
    endgenerate

    pwm_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .en_i      ((state_q == ARMING) || (state_q == RUNNING)),
        .clr_i     (period_start),
        .timeout_o (wdog_to)
    );

    always_comb begin
        state_d    = state_q;
        arm_seen_d = arm_seen_q;
        fault_exit = 1'b0;
        if (state_q != FAULT && (fault_in || wdog_to)) begin
            state_d    = FAULT;
            arm_seen_d = 1'b0;
        end else begin
            case (state_q)
                DISABLED: begin
                    arm_seen_d = 1'b0;
                    if (run_req_q) state_d = ARMING;
                end
                ARMING: begin
                    if (!run_req_q) begin
                        state_d    = DISABLED;
                        arm_seen_d = 1'b0;
                    end else if (period_start) begin
                        // First pulse starts a period on the active values; second closes it
                        if (arm_seen_q) begin
                            state_d    = RUNNING;
                            arm_seen_d = 1'b0;
                        end else begin
                            arm_seen_d = 1'b1;
                        end
                    end
                end
                RUNNING: begin
                    if (!run_req_q && period_start) state_d = DISABLED;
                end
                FAULT: begin
                    if (fault_clr && !fault_in) begin
                        state_d    = DISABLED;
                        fault_exit = 1'b1;
                    end
                end
                default: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DISABLED;
            arm_seen_q  <= 1'b0;
            run_req_q   <= 1'b0;
            dten_req_q  <= 1'b0;
            dten_hold_q <= 1'b0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_seen_q <= arm_seen_d;
            wr_err_q   <= cfg_wr && pending_q;
            done_q     <= xfer;
            if (xfer) begin
                pending_q <= 1'b0;
            end else if (commit_take) begin
                pending_q <= stg_valid;
                cfg_err_q <= !stg_valid;
            end
            if (fault_exit) begin
                run_req_q <= 1'b0;
            end else if (ctrl_wr) begin
                run_req_q <= wr_data[0];
            end
            if (ctrl_wr) dten_req_q <= wr_data[1];
            if (state_q == DISABLED) dten_hold_q <= dten_req_q;
        end
    end

    assign lim_out        = lim_act_q;
    assign out_en         = (state_q == RUNNING);
    assign dten_out       = (state_q == DISABLED) ? dten_req_q :
                            (state_q == FAULT)    ? 1'b0 : dten_hold_q;
    assign commit_pending = pending_q;
    assign commit_done    = done_q;
    assign cfg_err        = cfg_err_q;
    assign wr_err         = wr_err_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed scenario bench for pwm_cfg_sequencer with a 16-cycle watchdog.
module tb_pwm_cfg_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit_req;
    logic        period_start;
    logic        fault_in;
    logic        fault_clr;
    logic [31:0] lim_out;
    logic [95:0] mat_out;
    logic [29:0] dt_out;
    logic        dten_out;
    logic        out_en;
    logic        commit_pending;
    logic        commit_done;
    logic        cfg_err;
    logic        wr_err;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_cfg_sequencer #(.WDOG_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .period_start   (period_start),
        .fault_in       (fault_in),
        .fault_clr      (fault_clr),
        .lim_out        (lim_out),
        .mat_out        (mat_out),
        .dt_out         (dt_out),
        .dten_out       (dten_out),
        .out_en         (out_en),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .cfg_err        (cfg_err),
        .wr_err         (wr_err),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        $display("wr addr=%0d data=%0d wr_err=%0b", a, d, wr_err);
    endtask

    task automatic pulse_ps();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        $display("period_start state=%0d out_en=%0b done=%0b lim=%0d", state, out_en, commit_done, lim_out);
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        $display("commit pending=%0b cfg_err=%0b", commit_pending, cfg_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (lim_out !== 32'd3) begin n_bad++; $display("FAIL rst_lim got=%0d exp=3", lim_out); end
        n_cmp++; if (mat_out !== {32'd2, 32'd2, 32'd2}) begin n_bad++; $display("FAIL rst_mat got=%h exp=all 2", mat_out); end
        n_cmp++; if (dt_out !== {10'h3FF, 10'h3FF, 10'h3FF}) begin n_bad++; $display("FAIL rst_dt got=%h exp=3fffffff", dt_out); end
        n_cmp++; if ({dten_out, out_en, commit_pending, commit_done, cfg_err, wr_err} !== 6'b0) begin n_bad++; $display("FAIL rst_flags got=%b exp=000000", {dten_out, out_en, commit_pending, commit_done, cfg_err, wr_err}); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    endtask

    task automatic test_commit();
        wr(3'd0, 32'd100);
        wr(3'd1, 32'd20); wr(3'd2, 32'd50); wr(3'd3, 32'd80);
        wr(3'd4, 32'd5);  wr(3'd5, 32'd5);  wr(3'd6, 32'd5);
        commit();
        n_cmp++; if (commit_pending !== 1'b1) begin n_bad++; $display("FAIL commit_pend got=%b exp=1", commit_pending); end
        repeat (9) tick();
        period_start = 1'b1;
        n_cmp++; if (lim_out !== 32'd3) begin n_bad++; $display("FAIL pre_edge_lim got=%0d exp=3", lim_out); end
        tick();
        period_start = 1'b0;
        $display("transfer lim=%0d done=%0b pending=%0b", lim_out, commit_done, commit_pending);
        n_cmp++; if (lim_out !== 32'd100) begin n_bad++; $display("FAIL xfer_lim got=%0d exp=100", lim_out); end
        n_cmp++; if (mat_out !== {32'd80, 32'd50, 32'd20}) begin n_bad++; $display("FAIL xfer_mat got=%h exp=80/50/20", mat_out); end
        n_cmp++; if (dt_out !== {10'd5, 10'd5, 10'd5}) begin n_bad++; $display("FAIL xfer_dt got=%h exp=5/5/5", dt_out); end
        n_cmp++; if ({commit_done, commit_pending} !== 2'b10) begin n_bad++; $display("FAIL xfer_done_pend got=%b exp=10", {commit_done, commit_pending}); end
        tick();
        n_cmp++; if (commit_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got=%b exp=0", commit_done); end
    endtask

    task automatic test_cfg_err();
        wr(3'd2, 32'd200);
        commit();
        n_cmp++; if ({cfg_err, commit_pending} !== 2'b10) begin n_bad++; $display("FAIL bad_mat got=%b exp=10", {cfg_err, commit_pending}); end
        pulse_ps();
        n_cmp++; if (mat_out !== {32'd80, 32'd50, 32'd20} || commit_done !== 1'b0) begin n_bad++; $display("FAIL bad_no_xfer got=%h/%b exp=80/50/20 done 0", mat_out, commit_done); end
        wr(3'd2, 32'd60);
        commit();
        n_cmp++; if ({cfg_err, commit_pending} !== 2'b01) begin n_bad++; $display("FAIL fix_mat got=%b exp=01", {cfg_err, commit_pending}); end
        pulse_ps();
        n_cmp++; if (mat_out !== {32'd80, 32'd60, 32'd20} || commit_done !== 1'b1) begin n_bad++; $display("FAIL fix_xfer got=%h/%b exp=80/60/20 done 1", mat_out, commit_done); end
        wr(3'd0, 32'd0);
        commit();
        n_cmp++; if ({cfg_err, commit_pending} !== 2'b10) begin n_bad++; $display("FAIL lim_zero got=%b exp=10", {cfg_err, commit_pending}); end
        wr(3'd0, 32'd80);
        commit();
        n_cmp++; if ({cfg_err, commit_pending} !== 2'b01) begin n_bad++; $display("FAIL mat_eq_lim got=%b exp=01", {cfg_err, commit_pending}); end
        pulse_ps();
        n_cmp++; if (lim_out !== 32'd80) begin n_bad++; $display("FAIL lim80_xfer got=%0d exp=80", lim_out); end
    endtask

    task automatic test_wr_err_and_coincident();
        commit();
        wr(3'd0, 32'd50);
        n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("FAIL wr_err_pulse got=%b exp=1", wr_err); end
        wr(3'd7, 32'd2);
        n_cmp++; if (wr_err !== 1'b0 || dten_out !== 1'b1) begin n_bad++; $display("FAIL ctrl_wr got=%b/%b exp=0/1", wr_err, dten_out); end
        pulse_ps();
        n_cmp++; if (lim_out !== 32'd80 || commit_done !== 1'b1) begin n_bad++; $display("FAIL rejected_lim got=%0d/%b exp=80/1", lim_out, commit_done); end
        commit_req = 1'b1; period_start = 1'b1;
        tick();
        commit_req = 1'b0; period_start = 1'b0;
        n_cmp++; if ({commit_pending, commit_done} !== 2'b10) begin n_bad++; $display("FAIL coincide got=%b exp=10", {commit_pending, commit_done}); end
        tick();
        pulse_ps();
        n_cmp++; if ({commit_pending, commit_done} !== 2'b01) begin n_bad++; $display("FAIL coincide_next got=%b exp=01", {commit_pending, commit_done}); end
        wr(3'd0, 32'd50);
        n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL wr_ok got=%b exp=0", wr_err); end
    endtask

    task automatic test_fsm_run();
        wr(3'd7, 32'd3);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL run_lag got=%0d exp=0", state); end
        tick();
        n_cmp++; if (state !== 2'd1 || out_en !== 1'b0) begin n_bad++; $display("FAIL arming got=%0d/%b exp=1/0", state, out_en); end
        wr(3'd7, 32'd1);
        n_cmp++; if (dten_out !== 1'b1) begin n_bad++; $display("FAIL dten_frozen got=%b exp=1", dten_out); end
        pulse_ps();
        n_cmp++; if (state !== 2'd1 || out_en !== 1'b0) begin n_bad++; $display("FAIL arm_ps1 got=%0d/%b exp=1/0", state, out_en); end
        pulse_ps();
        n_cmp++; if (state !== 2'd2 || out_en !== 1'b1) begin n_bad++; $display("FAIL arm_ps2 got=%0d/%b exp=2/1", state, out_en); end
        wr(3'd7, 32'd0);
        tick(); tick();
        n_cmp++; if (state !== 2'd2 || out_en !== 1'b1) begin n_bad++; $display("FAIL stop_wait got=%0d/%b exp=2/1", state, out_en); end
        pulse_ps();
        n_cmp++; if (state !== 2'd0 || out_en !== 1'b0 || dten_out !== 1'b0) begin n_bad++; $display("FAIL stop_done got=%0d/%b/%b exp=0/0/0", state, out_en, dten_out); end
    endtask

    task automatic test_fault();
        wr(3'd7, 32'd1);
        tick();
        pulse_ps(); pulse_ps();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL fault_pre got=%0d exp=2", state); end
        fault_in = 1'b1;
        tick();
        $display("fault_in state=%0d out_en=%0b", state, out_en);
        n_cmp++; if (state !== 2'd3 || out_en !== 1'b0) begin n_bad++; $display("FAIL fault_enter got=%0d/%b exp=3/0", state, out_en); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL clr_blocked got=%0d exp=3", state); end
        commit();
        n_cmp++; if ({commit_pending, cfg_err} !== 2'b00) begin n_bad++; $display("FAIL fault_commit got=%b exp=00", {commit_pending, cfg_err}); end
        fault_in = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL fault_hold got=%0d exp=3", state); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL fault_exit got=%0d exp=0", state); end
        tick(); tick();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL run_cleared got=%0d exp=0", state); end
    endtask

    task automatic test_wdog();
        wr(3'd7, 32'd1);
        tick();
        pulse_ps(); pulse_ps();
        repeat (15) tick();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL wdog_15 got=%0d exp=2", state); end
        tick();
        $display("wdog 16 cycles state=%0d", state);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL wdog_16 got=%0d exp=3", state); end
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL wdog_exit got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid_commit();
        wr(3'd0, 32'd100);
        wr(3'd7, 32'd2);
        commit();
        n_cmp++; if (commit_pending !== 1'b1) begin n_bad++; $display("FAIL mid_pend got=%b exp=1", commit_pending); end
        rst = 1'b1; tick(); rst = 1'b0;
        $display("reset mid-commit pending=%0b lim=%0d", commit_pending, lim_out);
        n_cmp++; if (lim_out !== 32'd3 || mat_out !== {32'd2, 32'd2, 32'd2} || dt_out !== {10'h3FF, 10'h3FF, 10'h3FF}) begin n_bad++; $display("FAIL mid_vals got=%0d/%h/%h exp=3/2s/3ffs", lim_out, mat_out, dt_out); end
        n_cmp++; if ({commit_pending, dten_out, cfg_err, state} !== 5'b0) begin n_bad++; $display("FAIL mid_flags got=%b exp=00000", {commit_pending, dten_out, cfg_err, state}); end
        pulse_ps();
        n_cmp++; if (lim_out !== 32'd3 || commit_done !== 1'b0) begin n_bad++; $display("FAIL mid_discard got=%0d/%b exp=3/0", lim_out, commit_done); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
        commit_req = 1'b0; period_start = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
        test_reset();
        test_commit();
        test_cfg_err();
        test_wr_err_and_coincident();
        test_fsm_run();
        test_fault();
        test_wdog();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
